axi4_sram_slave: RTL and testbench
==================================

Name: axi4_sram_slave

Overview:
- AXI4 responder (slave) backing a word-addressed SRAM array; the memory-side end of the IFU/LSU cache refill and writeback traffic.
- Serves INCR, WRAP and FIXED bursts on independent read and write channel state machines.
- Used as the simulation and FPGA main-memory model behind the instruction and data cache AXI4 masters.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 64, data bus width; fixed at 64 for this block.
- ID_W, 4, transaction ID width.
- MEM_WORDS, 4096, number of 64-bit words in the array (32 KiB).
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- RD_DELAY, 2, idle cycles inserted between AR handshake and first R beat (0 allowed).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- S_AXI_AWID  input  ID_W  write ID
- S_AXI_AWADDR  input  ADDR_W  write start byte address
- S_AXI_AWLEN  input  8  beats-1
- S_AXI_AWSIZE  input  3  log2 bytes per beat, max 3
- S_AXI_AWBURST  input  2  00 FIXED, 01 INCR, 10 WRAP
- S_AXI_AWLOCK/AWCACHE/AWPROT/AWQOS/AWREGION/AWUSER  input  1/4/3/4/4/1  accepted, ignored
- S_AXI_AWVALID  input  1 ; S_AXI_AWREADY  output  1
- S_AXI_WDATA  input  64 ; S_AXI_WSTRB  input  8 ; S_AXI_WLAST  input  1 ; S_AXI_WUSER  input  1 (ignored)
- S_AXI_WVALID  input  1 ; S_AXI_WREADY  output  1
- S_AXI_BID  output  ID_W ; S_AXI_BRESP  output  2 ; S_AXI_BUSER  output  1 (tied 0)
- S_AXI_BVALID  output  1 ; S_AXI_BREADY  input  1
- S_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST  input  ID_W/ADDR_W/8/3/2  read command, same encoding as AW
- S_AXI_ARLOCK/ARCACHE/ARPROT/ARQOS/ARREGION/ARUSER  input  1/4/3/4/4/1  accepted, ignored
- S_AXI_ARVALID  input  1 ; S_AXI_ARREADY  output  1
- S_AXI_RID  output  ID_W ; S_AXI_RDATA  output  64 ; S_AXI_RRESP  output  2 ; S_AXI_RLAST  output  1 ; S_AXI_RUSER  output  1 (tied 0)
- S_AXI_RVALID  output  1 ; S_AXI_RREADY  input  1

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0 except AWREADY=1 and ARREADY=1.
  - Both FSMs return to IDLE; any in-flight burst is aborted.
  - Memory contents are not cleared.
- Read FSM, R_IDLE -> R_WAIT -> R_DATA:
  - R_IDLE: ARREADY=1. On ARVALID&ARREADY, latch id, addr, len, size, burst; clear beat counter.
  - R_WAIT: lasts RD_DELAY cycles; skipped when RD_DELAY=0.
  - Entering R_DATA registers RDATA=mem[(addr-BASE_ADDR)>>3] and RRESP; RVALID=1, RID=latched id, RLAST=(beat==len).
  - RDATA/RRESP/RLAST stay stable while RVALID&!RREADY.
  - On RVALID&RREADY with beat<len: advance address, beat+1, load next word; next beat is valid in the following cycle (one beat per cycle under RREADY=1).
  - On RVALID&RREADY with RLAST: RVALID=0, go to R_IDLE; ARREADY=1 next cycle.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: AWREADY=1. On AW handshake, latch command; WREADY=1 from the next cycle.
  - W_DATA: each WVALID&WREADY writes byte lanes selected by WSTRB into mem at the current address, then advances the address.
  - After beat==len is accepted: WREADY=0, go to W_RESP with BVALID=1, BID=latched id.
  - W_RESP: on BREADY, go to W_IDLE.
  - Beat count governs completion; a WLAST value inconsistent with the count sets BRESP=2'b10.
- Address advance, with incr=1<<size:
  - FIXED: address unchanged.
  - INCR: addr+incr.
  - WRAP: bound=(len+1)<<size; addr=(addr & ~(bound-1)) | ((addr+incr) & (bound-1)). len must be 1/3/7/15; any other len is treated as INCR.
  - Burst 2'b11 is treated as INCR with response 2'b10.
- Narrow transfers: reads always return the full aligned 64-bit word; the master selects the lane. Writes rely on WSTRB only.
- Out of range (addr<BASE_ADDR or >=BASE_ADDR+MEM_WORDS*8):
  - Read beat returns RDATA=0, RRESP=2'b10.
  - Write beat is dropped; BRESP=2'b10 if any beat of the burst was out of range.
  - In-range beats: OKAY (2'b00).
- Read and write channels run concurrently. A write committed at edge N is visible to any read word loaded at edge N or later; an already-registered RDATA is not updated.
- Bursts crossing 4 KiB are not checked; the address simply increments.

Test Plan:
- INCR read: ARADDR=BASE+0x40, ARLEN=7, ARSIZE=3, RREADY=1, RD_DELAY=2 -> first RVALID 3 cycles after AR handshake; 8 consecutive beats mem[8..15]; RLAST only on beat 8; RID echoes ARID=4'h5; RRESP=0.
- WRAP read: ARADDR=BASE+0x58, ARLEN=7 -> word order 11,12,13,14,15,8,9,10.
- Strobed write: mem[2]=64'hFFFF_FFFF_FFFF_FFFF, single beat at BASE+0x10, WDATA=64'h1122_3344_5566_7788, WSTRB=8'h0F -> BRESP=0, BID echoed; readback 64'hFFFF_FFFF_5566_7788.
- Backpressure: 8-beat read with RREADY toggling pseudo-randomly -> RDATA/RLAST stable while stalled; all 8 words delivered in order; none skipped or duplicated.
- Error: read at 0x0000_0000 -> RDATA=0, RRESP=2'b10. 4-beat write at BASE+MEM_WORDS*8-0x10 -> first 2 words written, BRESP=2'b10, nothing past the end touched.
- Reset mid-burst: assert rst during beat 3 of an 8-beat read while a write burst is in W_DATA -> RVALID/WREADY/BVALID drop to 0 asynchronously; after release ARREADY=AWREADY=1; previously written words preserved.

Source files
------------

// File: rtl/axi4_sram_slave_if.sv
// AXI4 slave-side bus bundle for axi4_sram_slave.
// Groups the AW, W, B, AR and R channels under their S_AXI_* names.
//   slave  modport : the memory model (drives READY / B / R)
//   master modport : the requester (drives commands and write data)
interface axi4_sram_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
);
  // write address
  logic [ID_W-1:0]     S_AXI_AWID;
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [7:0]          S_AXI_AWLEN;
  logic [2:0]          S_AXI_AWSIZE;
  logic [1:0]          S_AXI_AWBURST;
  logic                S_AXI_AWLOCK;
  logic [3:0]          S_AXI_AWCACHE;
  logic [2:0]          S_AXI_AWPROT;
  logic [3:0]          S_AXI_AWQOS;
  logic [3:0]          S_AXI_AWREGION;
  logic                S_AXI_AWUSER;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  // write data
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WLAST;
  logic                S_AXI_WUSER;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  // write response
  logic [ID_W-1:0]     S_AXI_BID;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BUSER;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  // read address
  logic [ID_W-1:0]     S_AXI_ARID;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [7:0]          S_AXI_ARLEN;
  logic [2:0]          S_AXI_ARSIZE;
  logic [1:0]          S_AXI_ARBURST;
  logic                S_AXI_ARLOCK;
  logic [3:0]          S_AXI_ARCACHE;
  logic [2:0]          S_AXI_ARPROT;
  logic [3:0]          S_AXI_ARQOS;
  logic [3:0]          S_AXI_ARREGION;
  logic                S_AXI_ARUSER;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  // read data
  logic [ID_W-1:0]     S_AXI_RID;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RLAST;
  logic                S_AXI_RUSER;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST,
           S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_AWREGION,
           S_AXI_AWUSER, S_AXI_AWVALID,
           S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WUSER, S_AXI_WVALID,
           S_AXI_BREADY,
           S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST,
           S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARREGION,
           S_AXI_ARUSER, S_AXI_ARVALID,
           S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY,
           S_AXI_BID, S_AXI_BRESP, S_AXI_BUSER, S_AXI_BVALID,
           S_AXI_ARREADY,
           S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RUSER, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST,
           S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_AWREGION,
           S_AXI_AWUSER, S_AXI_AWVALID,
           S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WUSER, S_AXI_WVALID,
           S_AXI_BREADY,
           S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST,
           S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARREGION,
           S_AXI_ARUSER, S_AXI_ARVALID,
           S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY,
           S_AXI_BID, S_AXI_BRESP, S_AXI_BUSER, S_AXI_BVALID,
           S_AXI_ARREADY,
           S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RUSER, S_AXI_RVALID
  );
endinterface

// File: rtl/axi4_sram_slave.sv
// AXI4 slave backed by a word-addressed 64-bit SRAM array; main-memory model
// behind the I/D cache AXI4 masters. Independent read and write FSMs serve
// FIXED / INCR / WRAP bursts.
// Ports:
//   clk   : clock
//   rst   : asynchronous active-high reset (memory contents survive it)
//   s_axi : AXI4 slave bundle (AW/W/B/AR/R channels)
module axi4_sram_slave #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 64,
  parameter int                ID_W      = 4,
  parameter int                MEM_WORDS = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int                RD_DELAY  = 2
) (
  input  logic clk,
  input  logic rst,
  axi4_sram_slave_if.slave s_axi
);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int NB    = DATA_W / 8;
  // one past the last mapped byte, one bit wider so it cannot overflow
  localparam logic [ADDR_W:0] END_ADDR = {1'b0, BASE_ADDR} + (ADDR_W+1)'(MEM_WORDS * 8);
  localparam logic [15:0] RD_CNT_INIT = (RD_DELAY > 0) ? 16'(RD_DELAY - 1) : 16'd0;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } cmd_t;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  logic [DATA_W-1:0] mem [MEM_WORDS];

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < END_ADDR);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> 3);
  endfunction

  // Address of the beat after c.addr. WRAP with an illegal length falls back to INCR.
  function automatic logic [ADDR_W-1:0] next_addr(input cmd_t c);
    logic [ADDR_W-1:0] incr, mask, res;
    incr = ADDR_W'(1) << c.size;
    mask = (ADDR_W'({1'b0, c.len} + 9'd1) << c.size) - ADDR_W'(1);
    case (c.burst)
      2'b00:   res = c.addr;
      2'b10:   res = (c.len == 8'd1 || c.len == 8'd3 || c.len == 8'd7 || c.len == 8'd15)
                   ? ((c.addr & ~mask) | ((c.addr + incr) & mask))
                   : (c.addr + incr);
      default: res = c.addr + incr;
    endcase
    return res;
  endfunction

  // ---------------- state ----------------
  r_state_e          r_state_q, r_state_d;
  cmd_t              rcmd_q, rcmd_d;
  logic [7:0]        rbeat_q, rbeat_d;
  logic [15:0]       rcnt_q, rcnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rlast_q, rlast_d;

  w_state_e          w_state_q, w_state_d;
  cmd_t              wcmd_q, wcmd_d;
  logic [7:0]        wbeat_q, wbeat_d;
  logic              werr_q, werr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      rcmd_q    <= '0;
      rbeat_q   <= '0;
      rcnt_q    <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
      w_state_q <= W_IDLE;
      wcmd_q    <= '0;
      wbeat_q   <= '0;
      werr_q    <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rcmd_q    <= rcmd_d;
      rbeat_q   <= rbeat_d;
      rcnt_q    <= rcnt_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      w_state_q <= w_state_d;
      wcmd_q    <= wcmd_d;
      wbeat_q   <= wbeat_d;
      werr_q    <= werr_d;
    end
  end

  // ---------------- memory write port ----------------
  logic             mem_we;
  logic [IDX_W-1:0] mem_widx;

  assign mem_we   = (w_state_q == W_DATA) && s_axi.S_AXI_WVALID && in_range(wcmd_q.addr);
  assign mem_widx = word_idx(wcmd_q.addr);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++)
        if (s_axi.S_AXI_WSTRB[b]) mem[mem_widx][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
    end
  end

  // ---------------- write FSM ----------------
  always_comb begin
    w_state_d = w_state_q;
    wcmd_d    = wcmd_q;
    wbeat_d   = wbeat_q;
    werr_d    = werr_q;
    case (w_state_q)
      W_IDLE: if (s_axi.S_AXI_AWVALID) begin
        wcmd_d    = cmd_t'{id: s_axi.S_AXI_AWID, addr: s_axi.S_AXI_AWADDR, len: s_axi.S_AXI_AWLEN,
                           size: s_axi.S_AXI_AWSIZE, burst: s_axi.S_AXI_AWBURST};
        wbeat_d   = '0;
        werr_d    = (s_axi.S_AXI_AWBURST == 2'b11);
        w_state_d = W_DATA;
      end
      W_DATA: if (s_axi.S_AXI_WVALID) begin
        // beat count ends the burst; a disagreeing WLAST only flags the response
        if (!in_range(wcmd_q.addr) || (s_axi.S_AXI_WLAST != (wbeat_q == wcmd_q.len)))
          werr_d = 1'b1;
        if (wbeat_q == wcmd_q.len) begin
          w_state_d = W_RESP;
        end else begin
          wcmd_d.addr = next_addr(wcmd_q);
          wbeat_d     = wbeat_q + 8'd1;
        end
      end
      W_RESP: if (s_axi.S_AXI_BREADY) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // ---------------- read FSM ----------------
  logic              ld, ld_bad, ld_last;
  logic [ADDR_W-1:0] ld_addr;
  logic [IDX_W-1:0]  ld_idx;
  logic [DATA_W-1:0] ld_word;

  always_comb begin
    r_state_d = r_state_q;
    rcmd_d    = rcmd_q;
    rbeat_d   = rbeat_q;
    rcnt_d    = rcnt_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    ld        = 1'b0;
    ld_addr   = rcmd_q.addr;
    ld_bad    = (rcmd_q.burst == 2'b11);
    ld_last   = (rbeat_q == rcmd_q.len);
    case (r_state_q)
      R_IDLE: if (s_axi.S_AXI_ARVALID) begin
        rcmd_d  = cmd_t'{id: s_axi.S_AXI_ARID, addr: s_axi.S_AXI_ARADDR, len: s_axi.S_AXI_ARLEN,
                         size: s_axi.S_AXI_ARSIZE, burst: s_axi.S_AXI_ARBURST};
        rbeat_d = '0;
        if (RD_DELAY == 0) begin
          ld        = 1'b1;
          ld_addr   = s_axi.S_AXI_ARADDR;
          ld_bad    = (s_axi.S_AXI_ARBURST == 2'b11);
          ld_last   = (s_axi.S_AXI_ARLEN == 8'd0);
          r_state_d = R_DATA;
        end else begin
          rcnt_d    = RD_CNT_INIT;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rcnt_q == 16'd0) begin
          ld        = 1'b1;
          r_state_d = R_DATA;
        end else begin
          rcnt_d = rcnt_q - 16'd1;
        end
      end
      R_DATA: if (s_axi.S_AXI_RREADY) begin
        if (rlast_q) begin
          r_state_d = R_IDLE;
        end else begin
          ld          = 1'b1;
          ld_addr     = next_addr(rcmd_q);
          ld_last     = ((rbeat_q + 8'd1) == rcmd_q.len);
          rcmd_d.addr = ld_addr;
          rbeat_d     = rbeat_q + 8'd1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase

    // Word fetch; a write landing on the same word this edge is forwarded
    // so the read sees it, matching the memory array after the edge.
    ld_idx  = word_idx(ld_addr);
    ld_word = mem[ld_idx];
    if (mem_we && (mem_widx == ld_idx)) begin
      for (int b = 0; b < NB; b++)
        if (s_axi.S_AXI_WSTRB[b]) ld_word[8*b +: 8] = s_axi.S_AXI_WDATA[8*b +: 8];
    end
    if (!in_range(ld_addr)) ld_word = '0;

    if (ld) begin
      rdata_d = ld_word;
      rresp_d = (!in_range(ld_addr) || ld_bad) ? 2'b10 : 2'b00;
      rlast_d = ld_last;
    end
  end

  // ---------------- outputs ----------------
  assign s_axi.S_AXI_AWREADY = (w_state_q == W_IDLE);
  assign s_axi.S_AXI_WREADY  = (w_state_q == W_DATA);
  assign s_axi.S_AXI_BVALID  = (w_state_q == W_RESP);
  assign s_axi.S_AXI_BID     = wcmd_q.id;
  assign s_axi.S_AXI_BRESP   = (w_state_q == W_RESP && werr_q) ? 2'b10 : 2'b00;
  assign s_axi.S_AXI_BUSER   = 1'b0;

  assign s_axi.S_AXI_ARREADY = (r_state_q == R_IDLE);
  assign s_axi.S_AXI_RVALID  = (r_state_q == R_DATA);
  assign s_axi.S_AXI_RID     = rcmd_q.id;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RLAST   = rlast_q && (r_state_q == R_DATA);
  assign s_axi.S_AXI_RUSER   = 1'b0;

  // sideband fields carry no meaning for a plain memory
  logic unused_sideband;
  assign unused_sideband = ^{s_axi.S_AXI_AWLOCK, s_axi.S_AXI_AWCACHE, s_axi.S_AXI_AWPROT,
                             s_axi.S_AXI_AWQOS, s_axi.S_AXI_AWREGION, s_axi.S_AXI_AWUSER,
                             s_axi.S_AXI_WUSER,
                             s_axi.S_AXI_ARLOCK, s_axi.S_AXI_ARCACHE, s_axi.S_AXI_ARPROT,
                             s_axi.S_AXI_ARQOS, s_axi.S_AXI_ARREGION, s_axi.S_AXI_ARUSER};
endmodule

// File: tb/tb_axi4_sram_slave.sv
`timescale 1ns/1ps
module tb_axi4_sram_slave;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axi4_sram_slave_if #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) bus ();

  axi4_sram_slave #(
    .ADDR_W(32), .DATA_W(64), .ID_W(4), .MEM_WORDS(4096),
    .BASE_ADDR(32'h8000_0000), .RD_DELAY(2)
  ) dut (
    .clk(clk), .rst(rst), .s_axi(bus)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat(input int i);
    return {32'hC0DE_0000 + 32'(i), 32'h1234_0000 + 32'(i)};
  endfunction

  logic [63:0] wbuf [16];

  // ---------------- write burst ----------------
  task automatic axi_write(input string name, input logic [31:0] addr, input logic [7:0] len,
                           input logic [3:0] id, input logic [7:0] strb, input bit bad_last,
                           input logic [1:0] exp_resp);
    int beat, cyc;
    bus.S_AXI_AWID = id; bus.S_AXI_AWADDR = addr; bus.S_AXI_AWLEN = len;
    bus.S_AXI_AWSIZE = 3'd3; bus.S_AXI_AWBURST = 2'b01; bus.S_AXI_AWVALID = 1'b1;
    cyc = 0;
    while (!bus.S_AXI_AWREADY && cyc < 50) begin tick(); cyc++; end
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    beat = 0; cyc = 0;
    while (beat <= int'(len) && cyc < 200) begin
      bus.S_AXI_WVALID = 1'b1;
      bus.S_AXI_WDATA  = wbuf[beat];
      bus.S_AXI_WSTRB  = strb;
      bus.S_AXI_WLAST  = bad_last ? (beat == 0) : (beat == int'(len));
      if (bus.S_AXI_WREADY) beat++;
      tick(); cyc++;
    end
    bus.S_AXI_WVALID = 1'b0; bus.S_AXI_WLAST = 1'b0;
    chk({name, " wbeats"}, 64'(beat), 64'(int'(len) + 1));
    cyc = 0;
    while (!bus.S_AXI_BVALID && cyc < 50) begin tick(); cyc++; end
    chk({name, " bvalid"}, 64'(bus.S_AXI_BVALID), 64'd1);
    chk({name, " bid"}, 64'(bus.S_AXI_BID), 64'(id));
    chk({name, " bresp"}, 64'(bus.S_AXI_BRESP), 64'(exp_resp));
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    chk({name, " awready after"}, 64'(bus.S_AXI_AWREADY), 64'd1);
  endtask

  // ---------------- read burst ----------------
  task automatic axi_read(input string name, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id,
                          input logic [0:7][63:0] exp_data, input logic [1:0] exp_resp,
                          input bit rand_ready, input bit chk_lat);
    int beat, cyc;
    logic rr;
    bus.S_AXI_ARID = id; bus.S_AXI_ARADDR = addr; bus.S_AXI_ARLEN = len;
    bus.S_AXI_ARSIZE = size; bus.S_AXI_ARBURST = burst; bus.S_AXI_ARVALID = 1'b1;
    cyc = 0;
    while (!bus.S_AXI_ARREADY && cyc < 50) begin tick(); cyc++; end
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    cyc = 1;
    while (!bus.S_AXI_RVALID && cyc < 50) begin tick(); cyc++; end
    if (chk_lat) chk({name, " first rvalid latency"}, 64'(cyc), 64'd3);
    beat = 0; cyc = 0;
    while (beat <= int'(len) && cyc < 300) begin
      rr = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.S_AXI_RREADY = rr;
      if (bus.S_AXI_RVALID) begin
        chk($sformatf("%s rdata b%0d", name, beat), bus.S_AXI_RDATA, exp_data[beat]);
        chk($sformatf("%s rresp b%0d", name, beat), 64'(bus.S_AXI_RRESP), 64'(exp_resp));
        chk($sformatf("%s rlast b%0d", name, beat), 64'(bus.S_AXI_RLAST), 64'(beat == int'(len)));
        chk($sformatf("%s rid b%0d", name, beat), 64'(bus.S_AXI_RID), 64'(id));
        if (rr) beat++;
      end
      tick(); cyc++;
    end
    bus.S_AXI_RREADY = 1'b0;
    chk({name, " rbeats"}, 64'(beat), 64'(int'(len) + 1));
    chk({name, " rvalid drop"}, 64'(bus.S_AXI_RVALID), 64'd0);
    chk({name, " arready back"}, 64'(bus.S_AXI_ARREADY), 64'd1);
  endtask

  // ---------------- read vector table ----------------
  typedef struct packed {
    logic [31:0]     addr;
    logic [7:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
    logic [3:0]      id;
    logic [0:7][7:0] idx;   // expected word per beat; 8'hFF = out of range (zero)
    logic [1:0]      resp;
  } rvec_t;

  function automatic logic [0:7][63:0] exp_of(input logic [0:7][7:0] idx);
    logic [0:7][63:0] e;
    for (int b = 0; b < 8; b++) e[b] = (idx[b] == 8'hFF) ? 64'd0 : pat(int'(idx[b]));
    return e;
  endfunction

  rvec_t rv [9];

  initial begin
    logic [0:7][63:0] ed;
    int beat, cyc;

    rv[0] = '{BASE + 32'h40, 8'd7, 3'd3, 2'b01, 4'h5, {8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15}, 2'b00};
    rv[1] = '{BASE + 32'h58, 8'd7, 3'd3, 2'b10, 4'h3, {8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd8, 8'd9, 8'd10}, 2'b00};
    rv[2] = '{BASE + 32'h20, 8'd3, 3'd3, 2'b00, 4'h1, {8'd4, 8'd4, 8'd4, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0}, 2'b00};
    rv[3] = '{BASE + 32'h68, 8'd3, 3'd3, 2'b10, 4'h2, {8'd13, 8'd14, 8'd15, 8'd12, 8'd0, 8'd0, 8'd0, 8'd0}, 2'b00};
    rv[4] = '{BASE + 32'h30, 8'd2, 3'd3, 2'b10, 4'h6, {8'd6, 8'd7, 8'd8, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 2'b00};
    rv[5] = '{BASE + 32'h08, 8'd1, 3'd3, 2'b11, 4'h7, {8'd1, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 2'b10};
    rv[6] = '{32'h0000_0000, 8'd0, 3'd3, 2'b01, 4'h8, {8'hFF, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 2'b10};
    rv[7] = '{BASE + 32'h10, 8'd3, 3'd2, 2'b01, 4'h9, {8'd2, 8'd2, 8'd3, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0}, 2'b00};
    rv[8] = '{BASE - 32'h8,  8'd0, 3'd3, 2'b01, 4'hC, {8'hFF, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 2'b10};

    // master side idle
    bus.S_AXI_AWID = '0; bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0; bus.S_AXI_AWSIZE = '0;
    bus.S_AXI_AWBURST = '0; bus.S_AXI_AWLOCK = '0; bus.S_AXI_AWCACHE = '0; bus.S_AXI_AWPROT = '0;
    bus.S_AXI_AWQOS = '0; bus.S_AXI_AWREGION = '0; bus.S_AXI_AWUSER = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 1'b0; bus.S_AXI_WUSER = 1'b0;
    bus.S_AXI_WVALID = 1'b0; bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARID = '0; bus.S_AXI_ARADDR = '0; bus.S_AXI_ARLEN = '0; bus.S_AXI_ARSIZE = '0;
    bus.S_AXI_ARBURST = '0; bus.S_AXI_ARLOCK = '0; bus.S_AXI_ARCACHE = '0; bus.S_AXI_ARPROT = '0;
    bus.S_AXI_ARQOS = '0; bus.S_AXI_ARREGION = '0; bus.S_AXI_ARUSER = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;

    // reset values
    rst = 1'b1;
    tick(); tick();
    chk("rst arready", 64'(bus.S_AXI_ARREADY), 64'd1);
    chk("rst awready", 64'(bus.S_AXI_AWREADY), 64'd1);
    chk("rst rvalid",  64'(bus.S_AXI_RVALID),  64'd0);
    chk("rst wready",  64'(bus.S_AXI_WREADY),  64'd0);
    chk("rst bvalid",  64'(bus.S_AXI_BVALID),  64'd0);
    chk("rst rdata",   bus.S_AXI_RDATA,        64'd0);
    chk("rst rlast",   64'(bus.S_AXI_RLAST),   64'd0);
    chk("rst rresp",   64'(bus.S_AXI_RRESP),   64'd0);
    chk("rst bresp",   64'(bus.S_AXI_BRESP),   64'd0);
    rst = 1'b0;
    tick();

    // preload words 0..31
    for (int i = 0; i < 16; i++) wbuf[i] = pat(i);
    axi_write("preload0", BASE, 8'd15, 4'h1, 8'hFF, 1'b0, 2'b00);
    for (int i = 0; i < 16; i++) wbuf[i] = pat(16 + i);
    axi_write("preload1", BASE + 32'h80, 8'd15, 4'h2, 8'hFF, 1'b0, 2'b00);

    // table-driven read bursts
    for (int v = 0; v < 9; v++) begin
      ed = exp_of(rv[v].idx);
      axi_read($sformatf("rvec%0d", v), rv[v].addr, rv[v].len, rv[v].size, rv[v].burst,
               rv[v].id, ed, rv[v].resp, 1'b0, (v == 0));
    end

    // backpressure: RREADY random, every beat still in order and stable while stalled
    ed = exp_of(rv[0].idx);
    axi_read("bp", rv[0].addr, 8'd7, 3'd3, 2'b01, 4'h5, ed, 2'b00, 1'b1, 1'b0);

    // strobed write over an all-ones word
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    axi_write("ones", BASE + 32'h10, 8'd0, 4'h3, 8'hFF, 1'b0, 2'b00);
    wbuf[0] = 64'h1122_3344_5566_7788;
    axi_write("strb", BASE + 32'h10, 8'd0, 4'hA, 8'h0F, 1'b0, 2'b00);
    ed = '0; ed[0] = 64'hFFFF_FFFF_5566_7788;
    axi_read("strb rb", BASE + 32'h10, 8'd0, 3'd3, 2'b01, 4'h4, ed, 2'b00, 1'b0, 1'b0);

    // write straddling the end of memory
    wbuf[0] = 64'hD000_0000_0000_0000; wbuf[1] = 64'hD111_1111_1111_1111;
    wbuf[2] = 64'hD222_2222_2222_2222; wbuf[3] = 64'hD333_3333_3333_3333;
    axi_write("oob wr", BASE + 32'h7FF0, 8'd3, 4'hB, 8'hFF, 1'b0, 2'b10);
    ed = '0; ed[0] = 64'hD000_0000_0000_0000; ed[1] = 64'hD111_1111_1111_1111;
    axi_read("oob rb", BASE + 32'h7FF0, 8'd1, 3'd3, 2'b01, 4'h1, ed, 2'b00, 1'b0, 1'b0);
    ed = '0; ed[0] = pat(0); ed[1] = pat(1);
    axi_read("word0 kept", BASE, 8'd1, 3'd3, 2'b01, 4'h1, ed, 2'b00, 1'b0, 1'b0);
    ed = '0;
    axi_read("past end", BASE + 32'h8000, 8'd0, 3'd3, 2'b01, 4'h2, ed, 2'b10, 1'b0, 1'b0);

    // WLAST disagreeing with the beat count: data still lands, response flags it
    wbuf[0] = 64'hAAAA_0000_0000_0001; wbuf[1] = 64'hAAAA_0000_0000_0002;
    axi_write("wlast bad", BASE + 32'h200, 8'd1, 4'h6, 8'hFF, 1'b1, 2'b10);
    ed = '0; ed[0] = wbuf[0]; ed[1] = wbuf[1];
    axi_read("wlast rb", BASE + 32'h200, 8'd1, 3'd3, 2'b01, 4'h6, ed, 2'b00, 1'b0, 1'b0);

    // reset in the middle of a read burst with a write burst still open
    bus.S_AXI_AWID = 4'h4; bus.S_AXI_AWADDR = BASE + 32'h300; bus.S_AXI_AWLEN = 8'd7;
    bus.S_AXI_AWSIZE = 3'd3; bus.S_AXI_AWBURST = 2'b01; bus.S_AXI_AWVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID = 1'b1; bus.S_AXI_WDATA = 64'h5555_0000_0000_0300;
    bus.S_AXI_WSTRB = 8'hFF; bus.S_AXI_WLAST = 1'b0;
    tick();
    bus.S_AXI_WVALID = 1'b0;
    chk("mid wready", 64'(bus.S_AXI_WREADY), 64'd1);
    bus.S_AXI_ARID = 4'h7; bus.S_AXI_ARADDR = BASE + 32'h80; bus.S_AXI_ARLEN = 8'd7;
    bus.S_AXI_ARSIZE = 3'd3; bus.S_AXI_ARBURST = 2'b01; bus.S_AXI_ARVALID = 1'b1;
    tick();
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b1;
    beat = 0; cyc = 0;
    while (!(bus.S_AXI_RVALID && beat == 2) && cyc < 40) begin
      if (bus.S_AXI_RVALID) beat++;
      tick(); cyc++;
    end
    chk("mid beat3 rdata", bus.S_AXI_RDATA, pat(18));
    rst = 1'b1;
    #1;
    chk("async rvalid", 64'(bus.S_AXI_RVALID), 64'd0);
    chk("async wready", 64'(bus.S_AXI_WREADY), 64'd0);
    chk("async bvalid", 64'(bus.S_AXI_BVALID), 64'd0);
    bus.S_AXI_RREADY = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("post rst arready", 64'(bus.S_AXI_ARREADY), 64'd1);
    chk("post rst awready", 64'(bus.S_AXI_AWREADY), 64'd1);
    chk("post rst rvalid",  64'(bus.S_AXI_RVALID),  64'd0);
    ed = exp_of({8'd16, 8'd17, 8'd18, 8'd19, 8'd20, 8'd21, 8'd22, 8'd23});
    axi_read("post rst mem", BASE + 32'h80, 8'd7, 3'd3, 2'b01, 4'h7, ed, 2'b00, 1'b0, 1'b0);
    ed = '0; ed[0] = 64'hFFFF_FFFF_5566_7788; ed[1] = 64'h5555_0000_0000_0300;
    axi_read("post rst w2", BASE + 32'h10, 8'd0, 3'd3, 2'b01, 4'h1, ed, 2'b00, 1'b0, 1'b0);
    ed = '0; ed[0] = 64'h5555_0000_0000_0300;
    axi_read("pre-rst beat", BASE + 32'h300, 8'd0, 3'd3, 2'b01, 4'h1, ed, 2'b00, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  // hard stop in case something wedges outside the bounded loops
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1, "watchdog");
  end
endmodule
